// File: rtl/pipe_ctrl_fsm_if.sv
// Hazard inputs and pipeline-register controls between the 5-stage core and pipe_ctrl_fsm.
// master: the controller; slave: the pipeline datapath.
interface pipe_ctrl_fsm_if;
  logic       is_load_ex;
  logic [4:0] rd_ex;
  logic [4:0] rs1_id;
  logic [4:0] rs2_id;
  logic       rs1_used_id;
  logic       rs2_used_id;
  logic       mispredict_ex;
  logic       dmem_req_mem;
  logic       dmem_ready;

  logic       pc_en;
  logic       if_id_en;
  logic       if_id_flush;
  logic       id_ex_en;
  logic       id_ex_flush;
  logic       ex_mem_en;

  modport master (
    input  is_load_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           mispredict_ex, dmem_req_mem, dmem_ready,
    output pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en
  );

  modport slave (
    output is_load_ex, rd_ex, rs1_id, rs2_id, rs1_used_id, rs2_used_id,
           mispredict_ex, dmem_req_mem, dmem_ready,
    input  pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en
  );
endinterface

// File: rtl/pipe_ctrl_fsm.sv
// Pipeline sequencing controller: load-use bubbles, mispredict redirect window, memory-wait freeze.
// Optional perf counters are built only when PIPE_CTRL_PERF_EN is defined.
module pipe_ctrl_fsm #(
  parameter int unsigned REDIRECT_CYCLES = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  pipe_ctrl_fsm_if.master       ctrl,
  output logic [1:0]            state_o,
  output logic [31:0]           stall_cycles,
  output logic [31:0]           flush_events
);

  typedef enum logic [1:0] {
    RUN      = 2'b00,
    MEMWAIT  = 2'b01,
    REDIRECT = 2'b10,
    ILLEGAL  = 2'b11
  } state_t;

  localparam logic [3:0] LP_CNT_LOAD = 4'(REDIRECT_CYCLES - 1);

  state_t     r_state;
  state_t     r_saved;
  logic [3:0] r_cnt;

  state_t     w_eff;
  logic       w_lu;
  logic       w_frz;
  logic       w_acc_misp;
  logic       w_lu_stall;

  assign w_lu = ctrl.is_load_ex && (ctrl.rd_ex != 5'd0) &&
                ((ctrl.rs1_used_id && (ctrl.rs1_id == ctrl.rd_ex)) ||
                 (ctrl.rs2_used_id && (ctrl.rs2_id == ctrl.rd_ex)));
  assign w_frz = ctrl.dmem_req_mem && !ctrl.dmem_ready;

  // MEMWAIT behaves as the saved state on its release cycle, so ready releases the pipe at once.
  always_comb begin
    w_eff = RUN;
    case (r_state)
      MEMWAIT:  w_eff = r_saved;
      REDIRECT: w_eff = REDIRECT;
      default:  w_eff = RUN;
    endcase
  end

  assign w_acc_misp = !rst && !w_frz && (w_eff == RUN) && ctrl.mispredict_ex;
  assign w_lu_stall = !rst && !w_frz && (w_eff == RUN) && !ctrl.mispredict_ex && w_lu;

  always_comb begin
    ctrl.pc_en       = 1'b0;
    ctrl.if_id_en    = 1'b0;
    ctrl.if_id_flush = 1'b0;
    ctrl.id_ex_en    = 1'b0;
    ctrl.id_ex_flush = 1'b0;
    ctrl.ex_mem_en   = 1'b0;
    if (rst) begin
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
    end else if (w_frz) begin
      // everything held, nothing flushed
    end else if (w_eff == REDIRECT) begin
      ctrl.pc_en       = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
    end else if (w_acc_misp) begin
      ctrl.pc_en       = 1'b1;
      ctrl.if_id_en    = 1'b1;
      ctrl.if_id_flush = 1'b1;
      ctrl.id_ex_flush = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
    end else if (w_lu_stall) begin
      ctrl.id_ex_flush = 1'b1;
      ctrl.ex_mem_en   = 1'b1;
    end else begin
      ctrl.pc_en     = 1'b1;
      ctrl.if_id_en  = 1'b1;
      ctrl.id_ex_en  = 1'b1;
      ctrl.ex_mem_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= RUN;
      r_saved <= RUN;
      r_cnt   <= '0;
    end else if (w_frz) begin
      r_state <= MEMWAIT;
      if (r_state != MEMWAIT) begin
        r_saved <= (r_state == REDIRECT) ? REDIRECT : RUN;
      end
    end else begin
      case (w_eff)
        RUN: begin
          if (w_acc_misp && (REDIRECT_CYCLES > 1)) begin
            r_state <= REDIRECT;
            r_cnt   <= LP_CNT_LOAD;
          end else begin
            r_state <= RUN;
          end
        end
        REDIRECT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= RUN;
            r_cnt   <= '0;
          end else begin
            r_state <= REDIRECT;
            r_cnt   <= r_cnt - 4'd1;
          end
        end
        default: r_state <= RUN;
      endcase
    end
  end

  assign state_o = r_state;

`ifdef PIPE_CTRL_PERF_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_events;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_stall_cycles <= '0;
      r_flush_events <= '0;
    end else begin
      if ((w_frz || w_lu_stall) && (r_stall_cycles != '1)) begin
        r_stall_cycles <= r_stall_cycles + 32'd1;
      end
      if (w_acc_misp && (r_flush_events != '1)) begin
        r_flush_events <= r_flush_events + 32'd1;
      end
    end
  end

  assign stall_cycles = r_stall_cycles;
  assign flush_events = r_flush_events;
`else
  assign stall_cycles = '0;
  assign flush_events = '0;
`endif

endmodule

// File: tb/tb_pipe_ctrl_fsm.sv
// Directed bench for pipe_ctrl_fsm: REDIRECT_CYCLES=3 main DUT plus a REDIRECT_CYCLES=1 DUT on the same inputs.
module tb_pipe_ctrl_fsm;

  logic        clk;
  logic        rst;
  logic [1:0]  state3, state1;
  logic [31:0] stall3, flush3, stall1, flush1;
  int          n_total;
  int          n_bad;

  pipe_ctrl_fsm_if if3 ();
  pipe_ctrl_fsm_if if1 ();

  assign if1.is_load_ex    = if3.is_load_ex;
  assign if1.rd_ex         = if3.rd_ex;
  assign if1.rs1_id        = if3.rs1_id;
  assign if1.rs2_id        = if3.rs2_id;
  assign if1.rs1_used_id   = if3.rs1_used_id;
  assign if1.rs2_used_id   = if3.rs2_used_id;
  assign if1.mispredict_ex = if3.mispredict_ex;
  assign if1.dmem_req_mem  = if3.dmem_req_mem;
  assign if1.dmem_ready    = if3.dmem_ready;

  pipe_ctrl_fsm #(.REDIRECT_CYCLES(3)) u_dut3 (
    .clk(clk), .rst(rst), .ctrl(if3.master),
    .state_o(state3), .stall_cycles(stall3), .flush_events(flush3)
  );

  pipe_ctrl_fsm #(.REDIRECT_CYCLES(1)) u_dut1 (
    .clk(clk), .rst(rst), .ctrl(if1.master),
    .state_o(state1), .stall_cycles(stall1), .flush_events(flush1)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en}
  localparam logic [5:0] C_RST   = 6'b001010;
  localparam logic [5:0] C_FRZ   = 6'b000000;
  localparam logic [5:0] C_RUN   = 6'b110101;
  localparam logic [5:0] C_MISP  = 6'b111011;
  localparam logic [5:0] C_LU    = 6'b000011;
  localparam logic [5:0] C_REDIR = 6'b101011;

  function automatic logic [5:0] ctl3();
    return {if3.pc_en, if3.if_id_en, if3.if_id_flush, if3.id_ex_en, if3.id_ex_flush, if3.ex_mem_en};
  endfunction

  function automatic logic [5:0] ctl1();
    return {if1.pc_en, if1.if_id_en, if1.if_id_flush, if1.id_ex_en, if1.id_ex_flush, if1.ex_mem_en};
  endfunction

  function automatic logic [31:0] pv(input int unsigned n);
`ifdef PIPE_CTRL_PERF_EN
    return 32'(n);
`else
    return 32'd0 + 32'(n & 0);
`endif
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic ld, input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                       input logic u1, input logic u2, input logic mp, input logic req, input logic rdy);
    if3.is_load_ex    = ld;
    if3.rd_ex         = rd;
    if3.rs1_id        = s1;
    if3.rs2_id        = s2;
    if3.rs1_used_id   = u1;
    if3.rs2_used_id   = u2;
    if3.mispredict_ex = mp;
    if3.dmem_req_mem  = req;
    if3.dmem_ready    = rdy;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_total = 0;
    n_bad   = 0;
    rst = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rst_ctl", 32'(ctl3()), 32'(C_RST));
    check("rst_ctl_rc1", 32'(ctl1()), 32'(C_RST));
    tick();
    check("rst_state", 32'(state3), 32'd0);
    check("rst_stall", stall3, 32'd0);
    check("rst_flush", flush3, 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("run_ctl", 32'(ctl3()), 32'(C_RUN));

    // load-use via rs1
    tick();
    drive(1, 5, 5, 0, 1, 0, 0, 0, 0);
    check("lu_rs1_ctl", 32'(ctl3()), 32'(C_LU));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("lu_after_ctl", 32'(ctl3()), 32'(C_RUN));
    check("lu_stall1", stall3, pv(1));
    drive(1, 7, 0, 7, 0, 1, 0, 0, 0);
    check("lu_rs2_ctl", 32'(ctl3()), 32'(C_LU));
    tick();
    drive(1, 7, 0, 7, 0, 0, 0, 0, 0);
    check("lu_rs2_unused", 32'(ctl3()), 32'(C_RUN));
    check("lu_stall2", stall3, pv(2));
    drive(1, 0, 0, 0, 1, 1, 0, 0, 0);
    check("lu_rd0", 32'(ctl3()), 32'(C_RUN));
    tick();
    check("lu_rd0_stall", stall3, pv(2));

    // mispredict, 3-cycle window vs 1-cycle window
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("misp_ctl", 32'(ctl3()), 32'(C_MISP));
    check("misp_ctl_rc1", 32'(ctl1()), 32'(C_MISP));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("redir1_state", 32'(state3), 32'd2);
    check("redir1_ctl", 32'(ctl3()), 32'(C_REDIR));
    check("rc1_state", 32'(state1), 32'd0);
    check("rc1_ctl", 32'(ctl1()), 32'(C_RUN));
    check("misp_flush", flush3, pv(1));
    tick();
    drive(1, 5, 5, 0, 1, 0, 0, 0, 0);
    check("redir2_state", 32'(state3), 32'd2);
    check("redir2_ignore_lu", 32'(ctl3()), 32'(C_REDIR));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("redir_done_state", 32'(state3), 32'd0);
    check("redir_done_ctl", 32'(ctl3()), 32'(C_RUN));
    check("redir_no_lu_stall", stall3, pv(2));

    // memory wait: four frozen cycles, released in the ready cycle
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("mw0_ctl", 32'(ctl3()), 32'(C_FRZ));
    check("mw0_state", 32'(state3), 32'd0);
    for (int i = 1; i < 4; i++) begin
      tick();
      check($sformatf("mw%0d_state", i), 32'(state3), 32'd1);
      check($sformatf("mw%0d_ctl", i), 32'(ctl3()), 32'(C_FRZ));
    end
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 1);
    check("mw_rel_ctl", 32'(ctl3()), 32'(C_RUN));
    check("mw_rel_state", 32'(state3), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("mw_done_state", 32'(state3), 32'd0);
    check("mw_stall", stall3, pv(6));

    // freeze + mispredict + load-use together
    drive(1, 5, 5, 0, 1, 0, 1, 1, 0);
    check("sim0_ctl", 32'(ctl3()), 32'(C_FRZ));
    tick();
    check("sim1_ctl", 32'(ctl3()), 32'(C_FRZ));
    check("sim1_state", 32'(state3), 32'd1);
    tick();
    drive(1, 5, 5, 0, 1, 0, 1, 0, 0);
    check("sim_rel_ctl", 32'(ctl3()), 32'(C_MISP));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("sim_redir_state", 32'(state3), 32'd2);
    check("sim_stall", stall3, pv(8));
    check("sim_flush", flush3, pv(2));
    tick();
    check("sim_redir2_ctl", 32'(ctl3()), 32'(C_REDIR));
    tick();
    check("sim_done_state", 32'(state3), 32'd0);

    // freeze during second redirect cycle: counter holds
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    check("fr_flush1", 32'(ctl3()), 32'(C_MISP));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("fr_flush2", 32'(ctl3()), 32'(C_REDIR));
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    check("fr_frz1_ctl", 32'(ctl3()), 32'(C_FRZ));
    check("fr_frz1_state", 32'(state3), 32'd2);
    tick();
    check("fr_frz2_state", 32'(state3), 32'd1);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("fr_flush3", 32'(ctl3()), 32'(C_REDIR));
    check("fr_rel_state", 32'(state3), 32'd1);
    tick();
    check("fr_done_state", 32'(state3), 32'd0);
    check("fr_done_ctl", 32'(ctl3()), 32'(C_RUN));
    check("fr_stall", stall3, pv(10));
    check("fr_flush_cnt", flush3, pv(3));

    // reset mid-REDIRECT
    drive(0, 0, 0, 0, 0, 0, 1, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rr_state_pre", 32'(state3), 32'd2);
    rst = 1'b1;
    #1;
    check("rr_rst_ctl", 32'(ctl3()), 32'(C_RST));
    tick();
    check("rr_state", 32'(state3), 32'd0);
    check("rr_stall", stall3, 32'd0);
    check("rr_flush", flush3, 32'd0);
    rst = 1'b0;
    #1;
    check("rr_run_ctl", 32'(ctl3()), 32'(C_RUN));
    tick();
    check("rr_run_state", 32'(state3), 32'd0);
    check("rr_run_ctl2", 32'(ctl3()), 32'(C_RUN));

    // reset mid-MEMWAIT
    drive(0, 0, 0, 0, 0, 0, 0, 1, 0);
    tick();
    check("rm_state_pre", 32'(state3), 32'd1);
    rst = 1'b1;
    #1;
    check("rm_rst_ctl", 32'(ctl3()), 32'(C_RST));
    tick();
    check("rm_state", 32'(state3), 32'd0);
    rst = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0);
    check("rm_run_ctl", 32'(ctl3()), 32'(C_RUN));
    tick();
    check("rm_run_state", 32'(state3), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
